alu_seq: RTL and testbench

Registered execute-stage ALU for the RV32I core. It sits directly downstream of the ALU control decoder, consuming its 4-bit `alu_func` together with two 32-bit operands, and returns a registered result plus a zero flag to the branch/writeback logic. Non-shift operations complete in one cycle. Shifts run iteratively, one bit position per cycle, to avoid a barrel shifter. A valid/ready handshake sits on both sides.

---
 rtl/alu_seq.sv | 102 ++++++++++
 tb/tb_alu_seq.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered RV32I execute ALU with iterative one-bit-per-cycle shifter and valid/ready handshake
module alu_seq #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_func,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_result,
    output logic            alu_zero,
    output logic            alu_err
);
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLL = 4'd2, OP_SLT = 4'd3,
                           OP_SLTU = 4'd4, OP_XOR = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                           OP_OR = 4'd8, OP_AND = 4'd9, OP_BGE = 4'd10, OP_BGEU = 4'd11,
                           OP_EEE = 4'd15;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state, state_n;
    logic [XLEN-1:0] work, work_nx, res_c;
    logic [SHW-1:0]  cnt, shamt;
    logic [3:0]      kind;
    logic            err_c, is_shift, start_shift, accept;

    assign shamt       = in_b[SHW-1:0];
    assign in_ready    = (state == IDLE) || (state == DONE && out_ready);
    assign accept      = in_valid && in_ready;
    assign out_valid   = (state == DONE);
    assign is_shift    = (alu_func == OP_SLL) || (alu_func == OP_SRL) || (alu_func == OP_SRA);
    assign start_shift = is_shift && (shamt != '0);
    // SRA keeps the sign bit in place each step, so the fill is always the original in_a msb
    assign work_nx = (kind == OP_SLL) ? work << 1 :
                     (kind == OP_SRL) ? work >> 1 : XLEN'($signed(work) >>> 1);

    always_comb begin
        res_c = '0;
        err_c = 1'b0;
        case (alu_func)
            OP_ADD:                 res_c = in_a + in_b;
            OP_SUB:                 res_c = in_a - in_b;
            OP_XOR:                 res_c = in_a ^ in_b;
            OP_OR:                  res_c = in_a | in_b;
            OP_AND:                 res_c = in_a & in_b;
            OP_SLT:                 res_c = XLEN'($signed(in_a) < $signed(in_b));
            OP_SLTU:                res_c = XLEN'(in_a < in_b);
            OP_BGE:                 res_c = XLEN'($signed(in_a) >= $signed(in_b));
            OP_BGEU:                res_c = XLEN'(in_a >= in_b);
            OP_SLL, OP_SRL, OP_SRA: res_c = in_a;
            OP_EEE:                 err_c = 1'b1;
            default:                err_c = 1'b1;
        endcase
    end

    always_comb begin
        state_n = state;
        if (accept)
            state_n = start_shift ? SHIFT : DONE;
        else if (state == SHIFT && cnt == SHW'(1))
            state_n = DONE;
        else if (state == DONE && out_ready)
            state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            work       <= '0;
            cnt        <= '0;
            kind       <= '0;
            alu_result <= '0;
            alu_zero   <= 1'b0;
            alu_err    <= 1'b0;
        end else if (accept && start_shift) begin
            work <= in_a;
            cnt  <= shamt;
            kind <= alu_func;
        end else if (accept) begin
            alu_result <= res_c;
            alu_zero   <= (res_c == '0);
            alu_err    <= err_c;
        end else if (state == SHIFT) begin
            work <= work_nx;
            cnt  <= cnt - SHW'(1);
            if (cnt == SHW'(1)) begin
                alu_result <= work_nx;
                alu_zero   <= (work_nx == '0);
                alu_err    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized and directed self-checking bench for alu_seq against a behavioural model
module tb_alu_seq;
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLL = 4'd2, OP_SLT = 4'd3,
                           OP_SLTU = 4'd4, OP_XOR = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                           OP_OR = 4'd8, OP_AND = 4'd9, OP_BGE = 4'd10, OP_BGEU = 4'd11,
                           OP_EEE = 4'd15;

    logic        clk = 1'b0;
    logic        rstn, in_valid, in_ready, out_valid, out_ready, alu_zero, alu_err;
    logic [3:0]  alu_func;
    logic [31:0] in_a, in_b, alu_result;
    int          n_chk = 0, n_fail = 0;

    alu_seq #(.XLEN(32), .SHW(5)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .alu_func(alu_func), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
        .out_ready(out_ready), .alu_result(alu_result), .alu_zero(alu_zero), .alu_err(alu_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // {err, result} straight from the ISA definitions
    function automatic logic [32:0] model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            OP_ADD:  return {1'b0, a + b};
            OP_SUB:  return {1'b0, a - b};
            OP_XOR:  return {1'b0, a ^ b};
            OP_OR:   return {1'b0, a | b};
            OP_AND:  return {1'b0, a & b};
            OP_SLL:  return {1'b0, a << b[4:0]};
            OP_SRL:  return {1'b0, a >> b[4:0]};
            OP_SRA:  return {1'b0, 32'($signed(a) >>> b[4:0])};
            OP_SLT:  return {32'd0, $signed(a) < $signed(b)};
            OP_SLTU: return {32'd0, a < b};
            OP_BGE:  return {32'd0, $signed(a) >= $signed(b)};
            OP_BGEU: return {32'd0, a >= b};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    function automatic bit is_sh(input logic [3:0] f);
        return f == OP_SLL || f == OP_SRL || f == OP_SRA;
    endfunction

    task automatic run_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b, input int stall);
        logic [32:0] m;
        int lat, exp_lat;
        m = model(f, a, b);
        exp_lat = (is_sh(f) && b[4:0] != 5'd0) ? 1 + int'(b[4:0]) : 1;
        chk("start_rdy", 32'(in_ready), 32'd1);
        in_valid = 1'b1; alu_func = f; in_a = a; in_b = b; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; alu_func = 4'($urandom); in_a = $urandom; in_b = $urandom;
        lat = 1;
        while (!out_valid && lat < 40) begin
            chk("busy_rdy", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("valid", 32'(out_valid), 32'd1);
        chk("result", alu_result, m[31:0]);
        chk("zero", 32'(alu_zero), 32'(m[31:0] == 32'd0));
        chk("err", 32'(alu_err), 32'(m[32]));
        for (int i = 0; i < stall; i++) begin
            chk("stall_rdy", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_result", alu_result, m[31:0]);
            chk("stall_err", 32'(alu_err), 32'(m[32]));
        end
        out_ready = 1'b1; #1;
        chk("drain_rdy", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("drained", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [3:0]  b2b_f [3];
        logic [31:0] b2b_a [3], b2b_b [3];
        logic [32:0] m;
        int seen;
        rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; alu_func = '0; in_a = '0; in_b = '0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_result", alu_result, 32'd0);
        chk("rst_rdy", 32'(in_ready), 32'd1);
        chk("rst_err", 32'(alu_err), 32'd0);

        run_op(OP_ADD, 32'hFFFF_FFFF, 32'd1, 3);
        run_op(OP_SUB, 32'd3, 32'd5, 3);
        run_op(OP_SRA, 32'h8000_0000, 32'd4, 1);
        run_op(OP_SRL, 32'h8000_0000, 32'd4, 0);
        run_op(OP_SLL, 32'd1, 32'd0, 0);
        run_op(OP_SLL, 32'd1, 32'd31, 0);
        run_op(OP_SLT, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(OP_BGE, 32'd5, 32'd5, 0);
        run_op(OP_BGEU, 32'd1, 32'hFFFF_FFFF, 0);
        run_op(OP_XOR, 32'h1234, 32'h1234, 0);
        run_op(OP_SRA, 32'h4000_0001, 32'd31, 0);

        b2b_f = '{OP_ADD, OP_OR, OP_EEE};
        b2b_a = '{32'd7, 32'hF0F0_0000, 32'd9};
        b2b_b = '{32'd8, 32'h0000_0F0F, 32'd9};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; alu_func = b2b_f[i]; in_a = b2b_a[i]; in_b = b2b_b[i];
            m = model(b2b_f[i], b2b_a[i], b2b_b[i]);
            @(posedge clk); #1;
            chk("b2b_valid", 32'(out_valid), 32'd1);
            chk("b2b_result", alu_result, m[31:0]);
            chk("b2b_err", 32'(alu_err), 32'(m[32]));
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("b2b_end", 32'(out_valid), 32'd0);

        in_valid = 1'b1; alu_func = OP_SLL; in_a = 32'd1; in_b = 32'd20;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_rdy", 32'(in_ready), 32'd1);
        chk("mid_rst_result", alu_result, 32'd0);
        seen = 0;
        repeat (25) begin @(posedge clk); #1; seen += int'(out_valid); end
        chk("mid_rst_no_result", 32'(seen), 32'd0);
        run_op(OP_ADD, 32'd2, 32'd2, 0);

        for (int k = 0; k < 40; k++) begin
            logic [3:0]  f;
            logic [31:0] a, b;
            f = 4'($urandom_range(0, 15));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            run_op(f, a, b, int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
